// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings (HTRANS, HSIZE, HRESP) and the SRAM slave FSM state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_OKAY_LAST,
    ST_ERR1,
    ST_ERR2
  } st_e;
endpackage

// File: rtl/ahb_byte_lane_gen.sv
// ahb_byte_lane_gen: size + addr_lo -> little-endian 4-bit write strobe (strb) and legal-alignment flag (aligned)
module ahb_byte_lane_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       aligned
);
  assign strb = size == HSIZE_WORD ? 4'b1111 :
                size == HSIZE_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                size == HSIZE_BYTE ? 4'b0001 << addr_lo : 4'b0000;
  assign aligned = size == HSIZE_WORD ? addr_lo == 2'b00 :
                   size == HSIZE_HALF ? !addr_lo[0] : size == HSIZE_BYTE;
endmodule

// File: rtl/ahb_sram_ws_slave.sv
// ahb_sram_ws_slave: AHB-Lite word SRAM responder with WAIT_STATES stalls and two-cycle ERROR; in HCLK/HRESET/HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY, out HREADYOUT/HRESP/HRDATA
module ahb_sram_ws_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
  parameter int SIZE = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int AW = $clog2(SIZE);
  localparam int IW = AW > 2 ? AW - 2 : 1;
  st_e state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [SIZE/4];
  logic [31:0] off;
  logic [IW-1:0] idx_q;
  logic [3:0] strb, strb_q;
  logic write_q, aligned, legal, ready, accept, unused;
  ahb_byte_lane_gen lane (.size(HSIZE), .addr_lo(HADDR[1:0]), .strb(strb), .aligned(aligned));
  assign off = HADDR - BASE_ADDR;
  assign legal = HADDR >= BASE_ADDR && off < 32'(SIZE) && aligned;
  assign ready = state != ST_WAIT && state != ST_ERR1;
  assign accept = HSEL && HREADY && HTRANS[1] && ready;
  assign unused = ^{HTRANS[0], off[31:IW+2]};
  always_comb begin
    state_n = ST_IDLE;
    cnt_n = cnt;
    if (state == ST_WAIT) begin
      state_n = cnt == 4'd0 ? ST_OKAY_LAST : ST_WAIT;
      cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end else if (state == ST_ERR1) state_n = ST_ERR2;
    else if (accept) begin
      state_n = !legal ? ST_ERR1 : WAIT_STATES == 0 ? ST_OKAY_LAST : ST_WAIT;
      cnt_n = legal && WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
    end
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
      cnt <= 4'd0;
      write_q <= 1'b0;
      strb_q <= 4'd0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        write_q <= HWRITE;
        strb_q <= strb;
        idx_q <= off[IW+1:2];
      end
    end
  end
  always_ff @(posedge HCLK) begin
    if (state == ST_OKAY_LAST && write_q)
      for (int b = 0; b < 4; b++)
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
  end
  assign HREADYOUT = ready;
  assign HRESP = state == ST_ERR1 || state == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = state == ST_OKAY_LAST && !write_q ? mem[idx_q] : 32'd0;
endmodule

// File: tb/tb_ahb_sram_ws_slave.sv
// tb_ahb_sram_ws_slave: randomized AHB traffic on three slaves (0, 2, 3 wait states) checked cycle by cycle against a transaction-level model
module tb_ahb_sram_ws_slave;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int SIZE = 4096;
  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic        wr;
    int          idx;
    logic [3:0]  mask;
    logic [31:0] wd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] sel, wr, stall, hready, hro, hresp;
  logic [31:0] addr [3];
  logic [1:0] trans [3];
  logic [2:0] size [3];
  logic [31:0] wdata [3];
  logic [31:0] hrdata [3];
  exp_t q [3][$];
  logic [31:0] mm [3][1024];
  int checks = 0;
  int passed = 0;
  logic smp_rdy, smp_resp;
  logic [31:0] smp_data;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign hready[g] = hro[g] & ~stall[g];
    ahb_sram_ws_slave #(.BASE_ADDR(BASE), .SIZE(SIZE), .WAIT_STATES(g == 0 ? 0 : g + 1)) dut (
      .HCLK(clk), .HRESET(rst), .HSEL(sel[g]), .HADDR(addr[g]), .HTRANS(trans[g]),
      .HWRITE(wr[g]), .HSIZE(size[g]), .HWDATA(wdata[g]), .HREADY(hready[g]),
      .HREADYOUT(hro[g]), .HRESP(hresp[g]), .HRDATA(hrdata[g]));
  end
  task automatic chk(string n, logic [33:0] act, logic [33:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask
  function automatic int ws(int d);
    return d == 0 ? 0 : d + 1;
  endfunction
  function automatic exp_t mk(logic r, logic e, logic [31:0] dat);
    exp_t x;
    x.rdy = r;
    x.resp = e;
    x.data = dat;
    x.wr = 1'b0;
    x.idx = 0;
    x.mask = 4'd0;
    x.wd = 32'd0;
    return x;
  endfunction
  function automatic bit legal(logic [31:0] a, logic [2:0] s);
    return a >= BASE && (a - BASE) < 32'(SIZE) && s <= 3'd2 && (a % (32'd1 << s)) == 32'd0;
  endfunction
  // An accepted transfer's whole data phase is predicted at once: stall beats then the final beat.
  task automatic accept(int d, logic w, logic [2:0] s, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    logic [31:0] o;
    if (!legal(a, s)) begin
      q[d].push_back(mk(1'b0, 1'b1, 32'd0));
      q[d].push_back(mk(1'b1, 1'b1, 32'd0));
      return;
    end
    repeat (ws(d)) q[d].push_back(mk(1'b0, 1'b0, 32'd0));
    o = a - BASE;
    e = mk(1'b1, 1'b0, 32'd0);
    e.idx = int'(o >> 2);
    e.wr = w;
    e.wd = wd;
    for (int i = 0; i < (1 << s); i++) e.mask[int'(o[1:0]) + i] = 1'b1;
    if (!w) e.data = mm[d][e.idx];
    q[d].push_back(e);
  endtask
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      exp_t e;
      e = mk(1'b1, 1'b0, 32'd0);
      if (rst) q[d].delete();
      else if (q[d].size() > 0) e = q[d].pop_front();
      if (e.wr)
        for (int i = 0; i < 4; i++)
          if (e.mask[i]) mm[d][e.idx][8*i +: 8] = e.wd[8*i +: 8];
      chk($sformatf("dut%0d bus", d), {hro[d], hresp[d], hrdata[d]}, {e.rdy, e.resp, e.data});
    end
  end
  task automatic cycle(int d, logic s, logic [1:0] t, logic w, logic [2:0] sz, logic [31:0] a,
                       logic st, logic [31:0] wd, output bit acc);
    sel[d] = s;
    trans[d] = t;
    wr[d] = w;
    size[d] = sz;
    addr[d] = a;
    stall[d] = st;
    @(negedge clk);
    smp_rdy = hro[d];
    smp_resp = hresp[d];
    smp_data = hrdata[d];
    acc = s && t[1] && hro[d] && !st;
    @(posedge clk);
    if (acc && !rst) accept(d, w, sz, a, wd);
    #1;
    if (acc && w) wdata[d] = wd;
    sel[d] = 1'b0;
    trans[d] = 2'b00;
    stall[d] = 1'b0;
  endtask
  task automatic xfer(int d, logic w, logic [2:0] sz, logic [31:0] a, logic [31:0] wd, output int n);
    bit acc;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 32) begin
      cycle(d, 1'b1, 2'b10, w, sz, a, 1'b0, wd, acc);
      n++;
    end
    if (!acc) chk("xfer accept timeout", 34'd0, 34'd1);
  endtask
  task automatic idle(int d, int n);
    bit acc;
    repeat (n) cycle(d, 1'b0, 2'b00, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, acc);
  endtask
  task automatic smp(string n, logic r, logic e, logic [31:0] dat);
    chk(n, {smp_rdy, smp_resp, smp_data}, {r, e, dat});
  endtask
  initial begin
    int n, low;
    bit acc;
    for (int d = 0; d < 3; d++) begin
      sel[d] = 1'b0; wr[d] = 1'b0; stall[d] = 1'b0; addr[d] = 32'd0;
      trans[d] = 2'b00; size[d] = 3'd0; wdata[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 16; w++) xfer(d, 1'b1, 3'd2, BASE + 32'(4 * w), $urandom, n);
    xfer(0, 1'b1, 3'd2, BASE + 32'h10, 32'hDEADBEEF, n);
    xfer(0, 1'b0, 3'd2, BASE + 32'h10, 32'd0, n);
    chk("ws0 back-to-back accept cycles", 34'(n), 34'd1);
    idle(0, 1);
    smp("ws0 raw word", 1'b1, 1'b0, 32'hDEADBEEF);
    xfer(0, 1'b1, 3'd2, BASE + 32'h10, 32'h11223344, n);
    xfer(0, 1'b1, 3'd0, BASE + 32'h13, 32'hA5EEEEEE, n);
    xfer(0, 1'b0, 3'd2, BASE + 32'h10, 32'd0, n);
    idle(0, 1);
    smp("byte lane 3 write", 1'b1, 1'b0, 32'hA5223344);
    xfer(0, 1'b1, 3'd1, BASE + 32'h10, 32'hEEEE7788, n);
    xfer(0, 1'b0, 3'd2, BASE + 32'h10, 32'd0, n);
    idle(0, 1);
    smp("halfword low write", 1'b1, 1'b0, 32'hA5227788);
    xfer(0, 1'b1, 3'd2, BASE, 32'h0BADF00D, n);
    xfer(0, 1'b0, 3'd2, BASE + 32'h1000, 32'd0, n);
    idle(0, 1);
    smp("out of range err1", 1'b0, 1'b1, 32'd0);
    idle(0, 1);
    smp("out of range err2", 1'b1, 1'b1, 32'd0);
    xfer(0, 1'b1, 3'd2, BASE + 32'h2, 32'hFFFFFFFF, n);
    idle(0, 1);
    smp("misaligned err1", 1'b0, 1'b1, 32'd0);
    idle(0, 1);
    smp("misaligned err2", 1'b1, 1'b1, 32'd0);
    xfer(0, 1'b0, 3'd2, BASE, 32'd0, n);
    idle(0, 1);
    smp("memory kept after error", 1'b1, 1'b0, 32'h0BADF00D);
    cycle(0, 1'b1, 2'b01, 1'b0, 3'd2, BASE + 32'h10, 1'b0, 32'd0, acc);
    idle(0, 1);
    smp("busy is zero-wait okay", 1'b1, 1'b0, 32'd0);
    cycle(0, 1'b0, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 1'b0, 32'd0, acc);
    idle(0, 1);
    smp("unselected is zero-wait okay", 1'b1, 1'b0, 32'd0);
    cycle(0, 1'b1, 2'b10, 1'b0, 3'd2, BASE + 32'h10, 1'b1, 32'd0, acc);
    idle(0, 1);
    smp("hready low blocks accept", 1'b1, 1'b0, 32'd0);
    xfer(1, 1'b1, 3'd2, BASE + 32'h10, 32'hCAFEF00D, n);
    xfer(1, 1'b0, 3'd2, BASE + 32'h10, 32'd0, n);
    chk("ws2 held nonseq accept cycles", 34'(n), 34'd3);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1, 1);
      if (smp_rdy) break;
      low++;
    end
    chk("ws2 hreadyout low cycles", 34'(low), 34'd2);
    smp("ws2 read data", 1'b1, 1'b0, 32'hCAFEF00D);
    xfer(2, 1'b1, 3'd2, BASE + 32'h20, 32'h12345678, n);
    xfer(2, 1'b1, 3'd2, BASE + 32'h20, 32'h87654321, n);
    idle(2, 1);
    smp("ws3 in wait before reset", 1'b0, 1'b0, 32'd0);
    #2 rst = 1'b1;
    #1 chk("async reset outputs", {hro[2], hresp[2], hrdata[2]}, {1'b1, 1'b0, 32'd0});
    @(posedge clk);
    #2 rst = 1'b0;
    xfer(2, 1'b0, 3'd2, BASE + 32'h20, 32'd0, n);
    for (int i = 0; i < 10; i++) begin
      idle(2, 1);
      if (smp_rdy) break;
    end
    smp("write dropped by reset", 1'b1, 1'b0, 32'h12345678);
    for (int d = 0; d < 3; d++) begin
      repeat (200) begin
        logic [31:0] a;
        logic [2:0] sz;
        sz = $urandom_range(0, 7) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
        a = $urandom_range(0, 15) == 0 ? BASE + 32'(SIZE) + 32'($urandom_range(0, 7)) :
            $urandom_range(0, 15) == 0 ? BASE - 32'd1 - 32'($urandom_range(0, 7)) :
            BASE + 32'($urandom_range(0, 63));
        cycle(d, 1'($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), sz, a,
              1'($urandom_range(0, 9) == 0), $urandom, acc);
      end
      idle(d, 8);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
